alu_decode_stage: RTL

//  Decode stage that drives the ALU: takes a 32-bit RV32I instruction plus register-file operands, produces
//  the 4-bit ALU opcode and operands A/B, and registers them behind a valid/ready handshake.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/pipe_skid_buf.sv | 79 +++++++
 rtl/alu_decode_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, RV32I encoding constants and the decoded
// beat that travels from decode to the ALU inputs.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_ROL  = 4'd10
    } alu_ops_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_ROT  = 7'b0110000;

    localparam logic [11:0] IMM_ALL_ONES = 12'hfff;

    typedef struct packed {
        alu_ops_t    alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        illegal;
    } alu_beat_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with an optional second (skid) entry so
// the upstream ready can come from a flop instead of the downstream ready.
module pipe_skid_buf #(
    parameter type T    = logic [7:0],
    parameter bit  SKID = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    // A beat moves on a side only in a cycle where that side's valid and ready
    // are both high; valid never drops and data never changes while waiting.
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    T     main_q, main_d;
    T     skid_q, skid_d;
    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = main_valid_q & out_ready_i;

    generate
        if (SKID) begin : g_two_entry
            assign in_ready_o = ~rst & ~skid_valid_q;
        end else begin : g_one_entry
            assign in_ready_o = ~rst & (out_ready_i | ~main_valid_q);
        end
    endgenerate

    // With SKID=0 the ready equation guarantees main is free on every accept,
    // so the skid branch below is never taken and the entry folds away.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            if (out_fire) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                main_d       = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I integer decode feeding the ALU: picks opcode and operands from the
// instruction, then registers the result behind a skid buffer.
module alu_decode_stage #(
    parameter bit ENABLE_ROL = 1'b1,
    parameter bit SKID       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    import alu_pkg::*;

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    alu_ops_t    dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_illegal;
    alu_beat_t   dec_beat;
    alu_beat_t   out_beat;

    assign opc    = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'h000};
    assign shamt  = {27'd0, in_instr[24:20]};

    always_comb begin
        dec_op = ALU_NONE;
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        case (opc)
            OPC_OP: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE)     dec_op = ALU_ADD;
                        else if (funct7 == F7_ALT) dec_op = ALU_SUB;
                    end
                    F3_SLL: begin
                        if (funct7 == F7_BASE)                   dec_op = ALU_SLL;
                        else if (ENABLE_ROL && funct7 == F7_ROT) dec_op = ALU_ROL;
                    end
                    F3_XOR: if (funct7 == F7_BASE) dec_op = ALU_XOR;
                    F3_SR: begin
                        if (funct7 == F7_BASE)     dec_op = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_op = ALU_SRA;
                    end
                    F3_OR:  if (funct7 == F7_BASE) dec_op = ALU_OR;
                    F3_AND: if (funct7 == F7_BASE) dec_op = ALU_AND;
                    default: dec_op = ALU_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    F3_ADD_SUB: dec_op = ALU_ADD;
                    // xori with all-ones immediate is the canonical NOT idiom
                    F3_XOR: dec_op = (in_instr[31:20] == IMM_ALL_ONES) ? ALU_NOT : ALU_XOR;
                    F3_OR:  dec_op = ALU_OR;
                    F3_AND: dec_op = ALU_AND;
                    F3_SLL: begin
                        dec_b = shamt;
                        if (funct7 == F7_BASE) dec_op = ALU_SLL;
                    end
                    F3_SR: begin
                        dec_b = shamt;
                        if (funct7 == F7_BASE)     dec_op = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_op = ALU_SRA;
                    end
                    default: dec_op = ALU_NONE;
                endcase
            end
            OPC_LUI: begin
                dec_op = ALU_ADD;
                dec_a  = '0;
                dec_b  = imm_u;
            end
            OPC_AUIPC: begin
                dec_op = ALU_ADD;
                dec_a  = in_pc;
                dec_b  = imm_u;
            end
            default: dec_op = ALU_NONE;
        endcase
    end

    // Illegal beats still flow downstream, but with zeroed operands.
    always_comb begin
        dec_illegal      = (dec_op == ALU_NONE);
        dec_beat.alu_op  = dec_op;
        dec_beat.a       = dec_illegal ? 32'd0 : dec_a;
        dec_beat.b       = dec_illegal ? 32'd0 : dec_b;
        dec_beat.rd      = in_instr[11:7];
        dec_beat.illegal = dec_illegal;
    end

    pipe_skid_buf #(
        .T    (alu_beat_t),
        .SKID (SKID)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (dec_beat),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_beat)
    );

    assign out_alu_op  = out_beat.alu_op;
    assign out_a       = out_beat.a;
    assign out_b       = out_beat.b;
    assign out_rd      = out_beat.rd;
    assign out_illegal = out_beat.illegal;

endmodule
